result_unpacker: RTL and testbench
==================================

RESULT_UNPACKER -- requirements
Module: result_unpacker

Interface
REQ-001 Parameter DEPTH_BLOCKS, default 4, is the number of 128-bit blocks stored; it SHALL be a power of two, 2..8.
REQ-002 Parameter WORD_W, default 32, is the output word width; the block SHALL always be 4 words wide.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous clear of all stored blocks.
REQ-006 in_valid  input  1  in_block holds a block to store.
REQ-007 in_block  input  128  result block; [127:96] is word 0 and [31:0] is word 3.
REQ-008 in_ready  output  1  the block can accept a block this cycle.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_data  output  WORD_W  current word of the oldest stored block.
REQ-011 out_ready  input  1  the consumer takes out_data this cycle.
REQ-012 out_last  output  1  out_data is word 3 of its block.
REQ-013 level  output  $clog2(DEPTH_BLOCKS)+1  number of blocks stored, including a block that is partly read.
REQ-014 full, empty  output  1 each  level==DEPTH_BLOCKS, level==0.

Function
REQ-015 A push SHALL occur when in_valid && in_ready: in_block is written to slot wr_ptr, and wr_ptr increments modulo DEPTH_BLOCKS.
REQ-016 in_ready SHALL equal !full and SHALL NOT depend on out_ready in the same cycle; a push is refused when full, even if the last word is popped in that cycle.
REQ-017 out_valid SHALL equal !empty. A block pushed at edge N SHALL appear on out_data from cycle N+1 (one-cycle latency).
REQ-018 out_data SHALL be word w_idx of slot rd_ptr, where w_idx 0 selects in_block[127:96] and w_idx 3 selects [31:0]. Selection is a combinational mux from registered storage.
REQ-019 A pop SHALL occur when out_valid && out_ready. On a pop, w_idx increments.
REQ-020 On a pop with w_idx==3, w_idx SHALL wrap to 0, rd_ptr SHALL increment modulo DEPTH_BLOCKS, and the block is released.
REQ-021 out_last SHALL equal out_valid && (w_idx==3).
REQ-022 level SHALL change as follows:
- +1 on a push without a release;
- -1 on a release without a push;
- unchanged when a push and a release occur in the same cycle, or when neither occurs.
REQ-023 While out_valid is 1 and out_ready is 0, out_data, out_last, w_idx and rd_ptr SHALL hold.
REQ-024 A push into a non-empty buffer SHALL NOT disturb out_data or w_idx.
REQ-025 When out_valid is 0, pops SHALL be ignored; out_data value is don't-care but SHALL be 0 after reset.
REQ-026 flush SHALL clear wr_ptr, rd_ptr, w_idx and level at the next edge, and SHALL override a push or pop in the same cycle; block storage is not cleared.
REQ-027 Pointer wrap-around SHALL be exercised without loss. A push into slot DEPTH_BLOCKS-1 SHALL be followed by a push into slot 0.

Reset
REQ-028 While reset==0, the block SHALL set:
- wr_ptr, rd_ptr, w_idx and level to 0;
- in_ready to 1, out_valid to 0, out_last to 0, out_data to 0;
- empty to 1, full to 0.
REQ-029 Reset asserted mid-block (w_idx!=0) SHALL discard all partial and stored data. No word SHALL be output after reset until a new push.
REQ-030 Storage registers need no reset; out_data SHALL be forced to 0 while empty=1.

Structure
REQ-031 The shared package SHALL hold: AES_BLOCK_W=128, AES_WORDS=4, and the word-select function mapping w_idx to a bit slice.
REQ-032 One sub-module, result_word_mux, SHALL implement the 128-to-WORD_W select. All pointer, counter and handshake logic SHALL stay in result_unpacker.

Verification
REQ-033 Single block: push 0x00112233_44556677_8899AABB_CCDDEEFF with out_ready=1. Required response:
- out_valid rises 1 cycle after the push;
- words appear in order 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles;
- out_last is high on 0xCCDDEEFF only;
- empty=1 afterwards.
REQ-034 Fill: push 4 blocks with out_ready=0. Required response: level=4, full=1, in_ready=0. A fifth in_valid is refused, and the first block still reads out intact.
REQ-035 Backpressure: toggle out_ready 1,0,0,1 while reading. Required response: out_data holds during the 0 cycles; no word is duplicated or lost.
REQ-036 Simultaneous events: hold level=2 and pop word 3 in the same cycle as a push. Required response: level stays 2, and the next word is word 0 of the following block.
REQ-037 Wrap: stream 10 blocks with random out_ready. Required response: 40 words in order; pointers wrap twice without error.
REQ-038 Reset and flush: assert reset at w_idx=2. Required response: out_valid=0 and level=0 immediately. Repeat with flush, which takes effect at the next edge.

Source files
------------

// File: rtl/result_unpacker_pkg.sv
// rtl/result_unpacker_pkg.sv - shared constants and word-select helper for the result unpacker
package result_unpacker_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORDS   = 4;
    localparam int WIDX_W      = $clog2(AES_WORDS);
    localparam int LSB_W       = $clog2(AES_BLOCK_W);

    // Word 0 is the most significant word of the block, word 3 the least.
    function automatic logic [LSB_W-1:0] word_lsb(input logic [WIDX_W-1:0] w_idx,
                                                  input int word_w);
        int lsb;
        lsb = (AES_WORDS - 1 - int'(w_idx)) * word_w;
        return lsb[LSB_W-1:0];
    endfunction

endpackage

// File: rtl/result_word_mux.sv
// rtl/result_word_mux.sv - combinational select of one word out of a stored block
module result_word_mux
    import result_unpacker_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [AES_BLOCK_W-1:0] i_block,
    input  logic [WIDX_W-1:0]      i_w_idx,
    output logic [WORD_W-1:0]      o_word
);

    // Pick the word addressed by i_w_idx from the registered block.
    always_comb begin
        o_word = i_block[word_lsb(i_w_idx, WORD_W) +: WORD_W];
    end

endmodule

// File: rtl/result_unpacker.sv
// rtl/result_unpacker.sv - block buffer that streams stored 128-bit results out word by word
module result_unpacker
    import result_unpacker_pkg::*;
#(
    parameter  int DEPTH_BLOCKS = 4,
    parameter  int WORD_W       = 32,
    localparam int PTR_W        = $clog2(DEPTH_BLOCKS),
    localparam int LVL_W        = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WORD_W-1:0]      out_data,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [LVL_W-1:0]       level,
    output logic                   full,
    output logic                   empty
);

    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH_BLOCKS);
    localparam logic [WIDX_W-1:0] WIDX_ONE  = WIDX_W'(1);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(AES_WORDS - 1);

    logic [AES_BLOCK_W-1:0] r_mem [DEPTH_BLOCKS];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [WIDX_W-1:0]      r_w_idx;
    logic [LVL_W-1:0]       r_level;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_release;
    logic [WORD_W-1:0]      w_word;

    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);
    // Flush wins over any handshake in the same cycle, so it masks both.
    assign w_push    = in_valid && !w_full && !flush;
    assign w_pop     = !w_empty && out_ready && !flush;
    assign w_release = w_pop && (r_w_idx == WIDX_LAST);

    // Block storage: plain data registers, only written on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_block;
        end
    end

    // Pointers, word index and occupancy; flush clears them at the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_w_idx  <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_w_idx  <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_w_idx <= r_w_idx + WIDX_ONE;
            end
            if (w_release) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_release})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    result_word_mux #(
        .WORD_W (WORD_W)
    ) u_word_mux (
        .i_block (r_mem[r_rd_ptr]),
        .i_w_idx (r_w_idx),
        .o_word  (w_word)
    );

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_word;
    assign out_last  = !w_empty && (r_w_idx == WIDX_LAST);
    assign level     = r_level;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule

// File: tb/tb_result_unpacker.sv
// tb/tb_result_unpacker.sv - self-checking bench for result_unpacker
module tb_result_unpacker;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_block;
    logic         in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ready;
    logic         out_last;
    logic [2:0]   level;
    logic         full;
    logic         empty;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the words still to be delivered, oldest first.
    logic [31:0] mq[$];

    result_unpacker #(.DEPTH_BLOCKS(DEPTH), .WORD_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_block  (in_block),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    wire [39:0] obs_vec = {in_ready, out_valid, out_last, full, empty, level, out_data};

    function automatic int m_level();
        return (mq.size() + 3) / 4;
    endfunction

    function automatic logic [39:0] exp_vec();
        int          lv;
        logic [31:0] d;
        lv = m_level();
        d  = (mq.size() > 0) ? mq[0] : 32'd0;
        return {lv < DEPTH, mq.size() > 0, (mq.size() % 4) == 1, lv == DEPTH, lv == 0, 3'(lv), d};
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] b, input int k);
        return b[127 - 32*k -: 32];
    endfunction

    // Drive one cycle from a negedge and advance the reference at the posedge.
    task automatic step(input logic iv, input logic [127:0] blk, input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        in_block  = blk;
        out_ready = ordy;
        flush     = fl;
        do_push   = iv && (m_level() < DEPTH);
        do_pop    = ordy && (mq.size() > 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) for (int k = 0; k < 4; k++) mq.push_back(word_of(blk, k));
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs_vec !== 40'h88_0000_0000) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", obs_vec, 40'h88_0000_0000);
        end
        reset = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        n_tests++;
        if (obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_single_block();
        logic [127:0] blk;
        logic [31:0]  w_exp [4];
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        w_exp[0] = 32'h00112233; w_exp[1] = 32'h44556677;
        w_exp[2] = 32'h8899AABB; w_exp[3] = 32'hCCDDEEFF;
        step(1'b1, blk, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({out_valid, out_last, out_data} !== {1'b1, i == 3, w_exp[i]}) begin
                n_fail++;
                $display("FAIL single_word%0d got v%b l%b %h want v1 l%b %h",
                         i, out_valid, out_last, out_data, i == 3, w_exp[i]);
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_tests++;
        if ({empty, out_valid, level} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL single_empty got e%b v%b lvl%0d want e1 v0 lvl0", empty, out_valid, level);
        end
    endtask

    task automatic test_fill();
        logic [127:0] b [4];
        int guard;
        for (int i = 0; i < 4; i++) begin
            b[i] = rand_block();
            step(1'b1, b[i], 1'b0, 1'b0);
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL fill_push%0d got %h want %h", i, obs_vec, exp_vec());
            end
        end
        n_tests++;
        if ({level, full, in_ready} !== {3'd4, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_full got lvl%0d f%b r%b want lvl4 f1 r0", level, full, in_ready);
        end
        step(1'b1, rand_block(), 1'b0, 1'b0);
        n_tests++;
        if (level !== 3'd4 || obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL fill_refuse got %h want %h", obs_vec, exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (out_data !== word_of(b[0], i)) begin
                n_fail++;
                $display("FAIL fill_first_word%0d got %h want %h", i, out_data, word_of(b[0], i));
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        guard = 0;
        while (mq.size() > 0 && guard < 100) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL fill_drain got %h want %h", obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_backpressure();
        int          pat [10];
        logic [31:0] held;
        int          guard;
        pat = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1};
        step(1'b1, rand_block(), 1'b0, 1'b0);
        step(1'b1, rand_block(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            held = out_data;
            step(1'b0, '0, pat[i] != 0, 1'b0);
            n_tests++;
            if (obs_vec !== exp_vec() || (pat[i] == 0 && out_data !== held)) begin
                n_fail++;
                $display("FAIL backpressure_cyc%0d got %h want %h", i, obs_vec, exp_vec());
            end
        end
        guard = 0;
        while (mq.size() > 0 && guard < 100) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        n_tests++;
        if (obs_vec !== exp_vec() || !empty) begin
            n_fail++;
            $display("FAIL backpressure_drain got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        logic [127:0] b0, b1, b2;
        int guard;
        b0 = rand_block(); b1 = rand_block(); b2 = rand_block();
        step(1'b1, b0, 1'b0, 1'b0);
        step(1'b1, b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        n_tests++;
        if ({level, out_last} !== {3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_pre got lvl%0d l%b want lvl2 l1", level, out_last);
        end
        step(1'b1, b2, 1'b1, 1'b0);
        n_tests++;
        if (level !== 3'd2 || out_data !== word_of(b1, 0) || obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL simul_post got lvl%0d %h want lvl2 %h", level, out_data, word_of(b1, 0));
        end
        guard = 0;
        while (mq.size() > 0 && guard < 100) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0]  exp_words[$];
        logic [31:0]  rx_words[$];
        logic [127:0] blk;
        int  sent, cyc, bad;
        bit  iv, ordy;
        sent = 0; cyc = 0; bad = 0;
        while ((sent < 10 || mq.size() > 0) && cyc < 600) begin
            iv   = (sent < 10) && ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 2) != 0);
            blk  = rand_block();
            if (iv && m_level() < DEPTH) begin
                sent++;
                for (int k = 0; k < 4; k++) exp_words.push_back(word_of(blk, k));
            end
            if (out_valid && ordy) rx_words.push_back(out_data);
            step(iv, blk, ordy, 1'b0);
            cyc++;
            if (obs_vec !== exp_vec()) bad++;
        end
        n_tests++;
        if (bad != 0 || cyc >= 600) begin
            n_fail++;
            $display("FAIL wrap_cycle got %0d bad cycles in %0d want 0 within 600", bad, cyc);
        end
        n_tests++;
        if (rx_words.size() != 40 || rx_words != exp_words) begin
            n_fail++;
            $display("FAIL wrap_order got %0d words want 40 in order", rx_words.size());
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, rand_block(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        mq.delete();
        n_tests++;
        if ({out_valid, level, out_data} !== {1'b0, 3'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid got v%b lvl%0d %h want v0 lvl0 0", out_valid, level, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_tests++;
            if (out_valid !== 1'b0 || obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_idle%0d got %h want %h", i, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_flush_mid();
        logic [127:0] b2;
        int guard;
        step(1'b1, rand_block(), 1'b0, 1'b0);
        step(1'b1, rand_block(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        in_valid = 1'b1; in_block = rand_block(); out_ready = 1'b1; flush = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, level} !== {1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL flush_pre_edge got v%b lvl%0d want v1 lvl2", out_valid, level);
        end
        step(1'b1, in_block, 1'b1, 1'b1);
        n_tests++;
        if ({out_valid, empty, level, out_data} !== {1'b0, 1'b1, 3'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL flush_post got v%b e%b lvl%0d %h want v0 e1 lvl0 0",
                     out_valid, empty, level, out_data);
        end
        b2 = rand_block();
        step(1'b1, b2, 1'b0, 1'b0);
        n_tests++;
        if (out_data !== word_of(b2, 0) || obs_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL flush_repush got %h want %h", out_data, word_of(b2, 0));
        end
        guard = 0;
        while (mq.size() > 0 && guard < 100) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_fill();
        test_backpressure();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_flush_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
